popcnt_sequencer: RTL and testbench



---
 rtl/popcnt_pkg.sv | 20 ++
 rtl/bit_counter_4.sv | 9 +
 rtl/popcnt_sequencer.sv | 116 +++++++++++
 tb/tb_popcnt_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/popcnt_pkg.sv
// rtl/popcnt_pkg.sv - shared types and sizing helper for the population-count sequencer
package popcnt_pkg;

  typedef enum logic {
    WORD = 1'b0,
    BYTE = 1'b1
  } popcnt_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } popcnt_state_t;

  // Bits needed to hold a whole-word count of 0..data_w.
  function automatic int acc_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/bit_counter_4.sv
// rtl/bit_counter_4.sv - combinational popcount of one nibble
module Bit_counter_4 (
  input  logic [3:0] din,
  output logic [2:0] count
);

  assign count = 3'(din[0]) + 3'(din[1]) + 3'(din[2]) + 3'(din[3]);

endmodule

// File: rtl/popcnt_sequencer.sv
// rtl/popcnt_sequencer.sv - multi-cycle word/byte population count with valid/ready handshakes
module popcnt_sequencer
  import popcnt_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int SLICE  = 4 * LANES;
  localparam int BEATS  = DATA_W / SLICE;
  localparam int ACC_W  = acc_width(DATA_W);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  popcnt_state_t      state, state_next;
  popcnt_mode_t       mode;
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  byte_acc, byte_next;
  logic [ACC_W-1:0]   acc, acc_next, lane_total;
  logic [BEAT_W-1:0]  beat;
  logic [3:0]         pair;
  logic [2:0]         cnt [LANES];
  logic               accept, last_beat;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    Bit_counter_4 u_cnt (
      .din   (shreg[g*4 +: 4]),
      .count (cnt[g])
    );
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign last_beat = (beat == LAST_BEAT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // flush overrides every other transition, including an accept
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = COUNT;
        end
      end
      COUNT:   if (last_beat) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) begin
      accept     = 1'b0;
      state_next = IDLE;
    end
  end

  // Each lane pair is one byte; its count lands in slot beat*(LANES/2)+k.
  always_comb begin
    lane_total = '0;
    for (int i = 0; i < LANES; i++) lane_total = lane_total + ACC_W'(cnt[i]);
    acc_next  = acc + lane_total;
    byte_next = byte_acc;
    pair      = '0;
    for (int k = 0; k < LANES / 2; k++) begin
      pair = 4'(cnt[2*k]) + 4'(cnt[2*k+1]);
      byte_next[(int'(beat) * (LANES / 2) + k) * 8 +: 8] = {4'h0, pair};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      mode     <= WORD;
      acc      <= '0;
      byte_acc <= '0;
      beat     <= '0;
      out_data <= '0;
    end else if (flush) begin
      acc      <= '0;
      byte_acc <= '0;
      beat     <= '0;
    end else if (accept) begin
      shreg    <= in_data;
      mode     <= popcnt_mode_t'(in_mode);
      acc      <= '0;
      byte_acc <= '0;
      beat     <= '0;
    end else if (state == COUNT) begin
      shreg    <= shreg >> SLICE;
      acc      <= acc_next;
      byte_acc <= byte_next;
      beat     <= beat + BEAT_W'(1);
      if (last_beat)
        out_data <= (mode == BYTE) ? byte_next : DATA_W'(acc_next);
    end
  end

endmodule

// File: tb/tb_popcnt_sequencer.sv
// tb/tb_popcnt_sequencer.sv - directed table-driven bench for popcnt_sequencer
module tb_popcnt_sequencer;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_mode, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_data;

  int n_applied = 0;
  int n_miss    = 0;

  typedef struct {
    logic        mode;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  popcnt_sequencer #(.DATA_W(32), .LANES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, then presents one operand for exactly one accept edge.
  task automatic issue(input logic m, input logic [31:0] d);
    int w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    in_mode  = ~m;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic run_vec(input string nm, input logic m, input logic [31:0] d, input logic [31:0] exp);
    int lat;
    out_ready = 1'b1;
    issue(m, d);
    wait_valid(lat);
    check({nm, "_latency"}, 32'(lat), 32'd4);
    check({nm, "_data"}, out_data, exp);
    tick();
    check({nm, "_in_ready_after"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    int lat;
    logic stable;

    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0020};
    vecs[1] = '{1'b0, 32'h1234_5678, 32'h0000_000D};
    vecs[2] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{1'b1, 32'h800F_FF00, 32'h0104_0800};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'h0808_0808};
    vecs[5] = '{1'b1, 32'h1234_5678, 32'h0203_0404};
    vecs[6] = '{1'b0, 32'h8000_0001, 32'h0000_0002};
    vecs[7] = '{1'b1, 32'h0000_0000, 32'h0000_0000};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
    in_data = '0; out_ready = 1'b0;
    #12;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].mode, vecs[i].data, vecs[i].exp);

    // Backpressure: result must hold for 10 cycles, then retire once.
    out_ready = 1'b0;
    issue(1'b0, 32'hFFFF_FFFF);
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd4);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!(out_valid && busy && !in_ready && out_data == 32'h20)) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_retire", {29'd0, out_valid, busy, in_ready}, 32'b001);
    stable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid || busy) stable = 1'b0;
    end
    check("bp_single_handshake", 32'(stable), 32'd1);

    // Flush after two beats.
    issue(1'b0, 32'hFFFF_FFFF);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", {29'd0, out_valid, busy, in_ready}, 32'b001);
    stable = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) stable = 1'b0;
    end
    check("flush_no_valid", 32'(stable), 32'd1);
    run_vec("post_flush", 1'b0, 32'h0000_000F, 32'h0000_0004);

    // Flush alongside in_valid in IDLE blocks the accept.
    flush = 1'b1; in_valid = 1'b1; in_mode = 1'b0; in_data = 32'hFFFF_FFFF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_blocks_accept", {30'd0, busy, in_ready}, 32'b01);

    // DONE with out_ready and in_valid together: retire only, accept next cycle.
    out_ready = 1'b0;
    issue(1'b1, 32'h0000_00FF);
    wait_valid(lat);
    check("done_overlap_data", out_data, 32'h0000_0008);
    out_ready = 1'b1; in_valid = 1'b1; in_mode = 1'b0; in_data = 32'h0000_0003;
    tick();
    check("done_overlap_no_accept", {30'd0, busy, in_ready}, 32'b01);
    tick();
    in_valid = 1'b0;
    check("done_overlap_accept_next", 32'(busy), 32'd1);
    wait_valid(lat);
    check("done_overlap_latency", 32'(lat), 32'd4);
    check("done_overlap_result", out_data, 32'h0000_0002);
    tick();

    // Asynchronous reset while DONE.
    out_ready = 1'b0;
    issue(1'b0, 32'hFFFF_FFFF);
    wait_valid(lat);
    check("areset_pre_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_out_data", out_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_vec("post_reset", 1'b1, 32'h0301_7F10, 32'h0201_0701);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
